// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared definitions for the AXI-Stream packet arbiter slice: arbiter state
// encoding, default stream widths and the statistics counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned DEF_KEEP_W = DEF_DATA_W / 8;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axis_arb_pkt_counter.sv
// -----------------------------------------------------------------------------
// axis_arb_pkt_counter
// Free-running completed-packet counter for one arbiter requester. Wraps
// from all-ones to zero.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (count cleared to 0)
//   inc    - one-cycle pulse per completed last-beat handshake
//   count  - current packet count (CNT_W bits)
// -----------------------------------------------------------------------------
module axis_arb_pkt_counter
  import axis_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// axis_pkt_arbiter
// Two-requester AXI-Stream packet arbiter. A requester is granted from IDLE
// with one cycle of arbitration latency and keeps the grant until its tlast
// beat handshakes; ties in IDLE are broken round-robin against the
// last-served pointer. While granted, the owner's stream is passed through
// combinationally; in IDLE the merged output is all zero.
//
// Optional feature: define AXIS_ARB_STATS_EN to add per-requester completed
// packet counters on pkt_cnt0 / pkt_cnt1.
//
// Ports:
//   ap_clk, ap_rst_n          - clock, asynchronous active-low reset
//   s0_axis_*                 - requester 0 stream (CMAC ingress)
//   s1_axis_*                 - requester 1 stream (host/PCIe injection)
//   m_axis_*                  - merged output stream
//   grant                     - one-hot owner (01=s0, 10=s1, 00=none)
//   pkt_cnt0, pkt_cnt1        - packet counters (AXIS_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,

  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,

  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,

  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,

  output logic [1:0]        grant
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

  arb_state_e state_q, state_d;
  // Last-served pointer: 1 means s1 was served last, so s0 wins the next tie.
  logic       lsp_q, lsp_d;
  logic       done0, done1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      lsp_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      lsp_q   <= lsp_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    lsp_d          = lsp_q;
    done0          = 1'b0;
    done1          = 1'b0;
    grant          = 2'b00;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          state_d = lsp_q ? GRANT0 : GRANT1;
        end else if (s0_axis_tvalid) begin
          state_d = GRANT0;
        end else if (s1_axis_tvalid) begin
          state_d = GRANT1;
        end
      end

      GRANT0: begin
        grant          = 2'b01;
        s0_axis_tready = m_axis_tready;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tlast   = s0_axis_tlast;
        done0          = s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
        if (done0) begin
          state_d = IDLE;
          lsp_d   = 1'b0;
        end
      end

      GRANT1: begin
        grant          = 2'b10;
        s1_axis_tready = m_axis_tready;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tlast   = s1_axis_tlast;
        done1          = s1_axis_tvalid && m_axis_tready && s1_axis_tlast;
        if (done1) begin
          state_d = IDLE;
          lsp_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef AXIS_ARB_STATS_EN
  axis_arb_pkt_counter u_cnt0 (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .inc   (done0),
    .count (pkt_cnt0)
  );

  axis_arb_pkt_counter u_cnt1 (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .inc   (done1),
    .count (pkt_cnt1)
  );
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_arbiter
// Self-checking bench for axis_pkt_arbiter (32-bit data, 4-bit keep).
// Table of per-cycle vectors followed by hand-written multi-cycle sequences.
// The counter checks are compiled only with AXIS_ARB_STATS_EN defined.
// -----------------------------------------------------------------------------
module tb_axis_pkt_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam logic [KW-1:0] K0 = 4'hF;
  localparam logic [KW-1:0] K1 = 4'h3;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          s0_v, s0_r, s0_l;
  logic [DW-1:0] s0_d;
  logic          s1_v, s1_r, s1_l;
  logic [DW-1:0] s1_d;
  logic          m_v, m_r, m_l;
  logic [DW-1:0] m_d;
  logic [KW-1:0] m_k;
  logic [1:0]    grant;
`ifdef AXIS_ARB_STATS_EN
  logic [31:0]   pkt_cnt0, pkt_cnt1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  axis_pkt_arbiter #(
    .DATA_W (DW),
    .KEEP_W (KW)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .s0_axis_tvalid (s0_v),
    .s0_axis_tready (s0_r),
    .s0_axis_tdata  (s0_d),
    .s0_axis_tkeep  (K0),
    .s0_axis_tlast  (s0_l),
    .s1_axis_tvalid (s1_v),
    .s1_axis_tready (s1_r),
    .s1_axis_tdata  (s1_d),
    .s1_axis_tkeep  (K1),
    .s1_axis_tlast  (s1_l),
    .m_axis_tvalid  (m_v),
    .m_axis_tready  (m_r),
    .m_axis_tdata   (m_d),
    .m_axis_tkeep   (m_k),
    .m_axis_tlast   (m_l),
    .grant          (grant)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic          s0v;
    logic [DW-1:0] s0d;
    logic          s0l;
    logic          s1v;
    logic [DW-1:0] s1d;
    logic          s1l;
    logic          mr;
    logic [1:0]    eg;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic          er0;
    logic          er1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s0v, input logic [DW-1:0] s0d, input logic s0l,
                              input logic s1v, input logic [DW-1:0] s1d, input logic s1l,
                              input logic mr, input logic [1:0] eg, input logic ev,
                              input logic [DW-1:0] ed, input logic el,
                              input logic er0, input logic er1);
    vec_t v;
    v.s0v = s0v; v.s0d = s0d; v.s0l = s0l;
    v.s1v = s1v; v.s1d = s1d; v.s1l = s1l;
    v.mr  = mr;  v.eg  = eg;  v.ev  = ev;
    v.ed  = ed;  v.el  = el;  v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    s0_v = 1'b0; s0_d = '0; s0_l = 1'b0;
    s1_v = 1'b0; s1_d = '0; s1_l = 1'b0;
    m_r  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    drive_idle();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  // Sends one packet of n beats from source src with m_tready held high.
  task automatic send_pkt(input int src, input int n, input logic [DW-1:0] base);
    int b = 0;
    for (int cyc = 0; cyc < 30 && b < n; cyc++) begin
      @(negedge ap_clk);
      m_r = 1'b1;
      if (src == 0) begin
        s0_v = 1'b1; s0_d = base + DW'(b); s0_l = (b == n - 1);
      end else begin
        s1_v = 1'b1; s1_d = base + DW'(b); s1_l = (b == n - 1);
      end
      #1;
      if ((src == 0 && s0_r) || (src == 1 && s1_r)) b++;
    end
    @(negedge ap_clk);
    drive_idle();
    chk($sformatf("send_pkt src%0d beats", src), 64'(b), 64'(n));
  endtask

  initial begin : main
    logic [DW-1:0] cap[8];
    int            got;
    int            bi;
    logic [1:0]    alt_exp[8];

    ap_rst_n = 1'b0;
    drive_idle();
    #2;
    chk("reset grant",  64'(grant), 64'h0);
    chk("reset m_v",    64'(m_v),   64'h0);
    chk("reset s0_r",   64'(s0_r),  64'h0);
    chk("reset s1_r",   64'(s1_r),  64'h0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    //          s0v s0d           s0l s1v s1d           s1l mr  eg     ev  ed            el  r0  r1
    tbl.push_back(mk(1, 32'hA000_0001, 0, 0, 32'h0,         0, 1, 2'b00, 0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(1, 32'hA000_0001, 0, 0, 32'h0,         0, 1, 2'b01, 1, 32'hA000_0001, 0, 1, 0));
    tbl.push_back(mk(1, 32'hA000_0002, 0, 0, 32'h0,         0, 1, 2'b01, 1, 32'hA000_0002, 0, 1, 0));
    tbl.push_back(mk(1, 32'hA000_0003, 1, 0, 32'h0,         0, 1, 2'b01, 1, 32'hA000_0003, 1, 1, 0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 2'b00, 0, 32'h0,         0, 0, 0));
    // Tie with s0 served last: s1 wins; s0 stays blocked through s1's packet.
    tbl.push_back(mk(1, 32'hB000_0000, 1, 1, 32'hC000_0001, 0, 1, 2'b00, 0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(1, 32'hB000_0000, 1, 1, 32'hC000_0001, 0, 1, 2'b10, 1, 32'hC000_0001, 0, 0, 1));
    tbl.push_back(mk(1, 32'hB000_0000, 1, 1, 32'hC000_0002, 1, 1, 2'b10, 1, 32'hC000_0002, 1, 0, 1));
    tbl.push_back(mk(1, 32'hB000_0000, 1, 0, 32'h0,         0, 1, 2'b00, 0, 32'h0,         0, 0, 0));
    // Single-beat packet.
    tbl.push_back(mk(1, 32'hB000_0000, 1, 0, 32'h0,         0, 1, 2'b01, 1, 32'hB000_0000, 1, 1, 0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 2'b00, 0, 32'h0,         0, 0, 0));
    // Backpressure, mid-packet valid drop, and a stalled last beat.
    tbl.push_back(mk(1, 32'hD000_0001, 0, 0, 32'h0,         0, 0, 2'b00, 0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(1, 32'hD000_0001, 0, 0, 32'h0,         0, 0, 2'b01, 1, 32'hD000_0001, 0, 0, 0));
    tbl.push_back(mk(1, 32'hD000_0001, 0, 0, 32'h0,         0, 1, 2'b01, 1, 32'hD000_0001, 0, 1, 0));
    tbl.push_back(mk(0, 32'hD000_0002, 1, 1, 32'hC000_0009, 1, 1, 2'b01, 0, 32'hD000_0002, 1, 1, 0));
    tbl.push_back(mk(1, 32'hD000_0002, 1, 1, 32'hC000_0009, 1, 0, 2'b01, 1, 32'hD000_0002, 1, 0, 0));
    tbl.push_back(mk(1, 32'hD000_0002, 1, 1, 32'hC000_0009, 1, 1, 2'b01, 1, 32'hD000_0002, 1, 1, 0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 32'hC000_0009, 1, 1, 2'b00, 0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 32'hC000_0009, 1, 1, 2'b10, 1, 32'hC000_0009, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 2'b00, 0, 32'h0,         0, 0, 0));

    foreach (tbl[k]) begin
      @(negedge ap_clk);
      s0_v = tbl[k].s0v; s0_d = tbl[k].s0d; s0_l = tbl[k].s0l;
      s1_v = tbl[k].s1v; s1_d = tbl[k].s1d; s1_l = tbl[k].s1l;
      m_r  = tbl[k].mr;
      #1;
      chk($sformatf("row%0d grant", k), 64'(grant), 64'(tbl[k].eg));
      chk($sformatf("row%0d m_v",   k), 64'(m_v),   64'(tbl[k].ev));
      chk($sformatf("row%0d m_d",   k), 64'(m_d),   64'(tbl[k].ed));
      chk($sformatf("row%0d m_l",   k), 64'(m_l),   64'(tbl[k].el));
      chk($sformatf("row%0d m_k",   k), 64'(m_k),
          64'((tbl[k].eg == 2'b01) ? K0 : (tbl[k].eg == 2'b10) ? K1 : 4'h0));
      chk($sformatf("row%0d s0_r",  k), 64'(s0_r),  64'(tbl[k].er0));
      chk($sformatf("row%0d s1_r",  k), 64'(s1_r),  64'(tbl[k].er1));
    end

    // Both requesters continuously valid with single-beat packets after reset:
    // s0 first, then strict alternation with an idle cycle between packets.
    do_reset();
    alt_exp[0] = 2'b00; alt_exp[1] = 2'b01; alt_exp[2] = 2'b00; alt_exp[3] = 2'b10;
    alt_exp[4] = 2'b00; alt_exp[5] = 2'b01; alt_exp[6] = 2'b00; alt_exp[7] = 2'b10;
    for (int c = 0; c < 8; c++) begin
      @(negedge ap_clk);
      s0_v = 1'b1; s0_d = 32'h5050_0000; s0_l = 1'b1;
      s1_v = 1'b1; s1_d = 32'h5151_0000; s1_l = 1'b1;
      m_r  = 1'b1;
      #1;
      chk($sformatf("alt c%0d grant", c), 64'(grant), 64'(alt_exp[c]));
    end

    // 4-beat s0 packet with m_tready toggling: all beats once, in order.
    do_reset();
    got = 0;
    bi  = 0;
    for (int cyc = 0; cyc < 40 && bi < 4; cyc++) begin
      @(negedge ap_clk);
      s0_v = 1'b1; s0_d = 32'hF000_0000 + DW'(bi); s0_l = (bi == 3);
      m_r  = cyc[0];
      #1;
      if (m_v && m_r) begin
        if (got < 8) cap[got] = m_d;
        got++;
      end
      if (s0_r && s0_v) bi++;
    end
    @(negedge ap_clk);
    drive_idle();
    chk("toggle source beats", 64'(bi),  64'd4);
    chk("toggle sink beats",   64'(got), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("toggle beat%0d data", k), 64'(cap[k]), 64'(32'hF000_0000 + k));
    end
    #1;
    chk("toggle back to idle", 64'(grant), 64'h0);

    // Reset asserted on beat 2 of a 5-beat s1 packet.
    do_reset();
    @(negedge ap_clk);
    s1_v = 1'b1; s1_d = 32'hE000_0000; s1_l = 1'b0; m_r = 1'b1;
    @(negedge ap_clk);
    #1;
    chk("rst_mid beat1 grant", 64'(grant), 64'b10);
    @(negedge ap_clk);
    s1_d = 32'hE000_0001;
    s0_v = 1'b1; s0_d = 32'h0A0A_0A0A; s0_l = 1'b1;
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_mid grant",  64'(grant), 64'h0);
    chk("rst_mid m_v",    64'(m_v),   64'h0);
    chk("rst_mid s0_r",   64'(s0_r),  64'h0);
    chk("rst_mid s1_r",   64'(s1_r),  64'h0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("rst_mid release idle", 64'(grant), 64'h0);
    @(negedge ap_clk);
    #1;
    chk("rst_mid tie grant", 64'(grant), 64'b01);
    chk("rst_mid tie data",  64'(m_d),   64'(32'h0A0A_0A0A));
    @(negedge ap_clk);
    drive_idle();

`ifdef AXIS_ARB_STATS_EN
    do_reset();
    #1;
    chk("cnt0 reset", 64'(pkt_cnt0), 64'h0);
    chk("cnt1 reset", 64'(pkt_cnt1), 64'h0);
    send_pkt(0, 1, 32'h1000_0000);
    send_pkt(1, 2, 32'h2000_0000);
    send_pkt(0, 3, 32'h3000_0000);
    #1;
    chk("cnt0 after pkts", 64'(pkt_cnt0), 64'd2);
    chk("cnt1 after pkts", 64'(pkt_cnt1), 64'd1);
    force dut.u_cnt0.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt0.cnt_q;
    #1;
    chk("cnt0 preload", 64'(pkt_cnt0), 64'hFFFF_FFFF);
    send_pkt(0, 1, 32'h4000_0000);
    #1;
    chk("cnt0 wrap", 64'(pkt_cnt0), 64'h0);
    chk("cnt1 unchanged", 64'(pkt_cnt1), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
